// File: rtl/lu_arbiter.sv
// Round-robin arbiter that shares one combinational 16-bit logic unit among NREQ requesters.
// The granted request's result and flags land in a single registered response slot with backpressure.
module lu_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*16-1:0]        req_a,
    input  logic [NREQ*16-1:0]        req_b,
    input  logic [NREQ*4-1:0]         req_op,
    output logic [NREQ-1:0]           req_ready,
    output logic [15:0]               lu_a,
    output logic [15:0]               lu_b,
    output logic [3:0]                lu_op,
    input  logic [15:0]               lu_out,
    input  logic                      lu_eq,
    input  logic                      lu_gt,
    input  logic                      lu_za,
    input  logic                      lu_zb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [15:0]               rsp_data,
    output logic [3:0]                rsp_flags,
    output logic [15:0]               rsp_count
);

    localparam int IDW = $clog2(NREQ);
    localparam logic [IDW:0] NREQ_W = NREQ[IDW:0];
    localparam logic [IDW:0] ONE_W  = {{IDW{1'b0}}, 1'b1};

    // Index arithmetic modulo NREQ; NREQ need not be a power of two.
    function automatic logic [IDW-1:0] ring_add(input logic [IDW-1:0] base, input logic [IDW:0] off);
        logic [IDW:0] sum;
        sum = {1'b0, base} + off;
        if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
        end else begin
            sum = sum;
        end
        return sum[IDW-1:0];
    endfunction

    logic [IDW-1:0] ptr_r;
    logic           rsp_valid_r;
    logic [IDW-1:0] rsp_id_r;
    logic [15:0]    rsp_data_r;
    logic [3:0]     rsp_flags_r;
    logic [15:0]    rsp_count_r;

    logic           accept_ok_s;
    logic           found_s;
    logic [IDW-1:0] gnt_idx_s;
    logic           grant_s;

    assign accept_ok_s = !rsp_valid_r || rsp_ready;
    assign grant_s     = accept_ok_s && found_s;

    // Priority search from ptr upward; walking backwards lets the nearest candidate overwrite later ones.
    always_comb begin
        found_s   = 1'b0;
        gnt_idx_s = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            found_s   = found_s | req_valid[ring_add(ptr_r, (IDW+1)'(k))];
            gnt_idx_s = req_valid[ring_add(ptr_r, (IDW+1)'(k))] ? ring_add(ptr_r, (IDW+1)'(k)) : gnt_idx_s;
        end
    end

    // Grant vector and operand mux toward the logic unit; zeros when nothing is granted.
    always_comb begin
        req_ready = '0;
        lu_a      = 16'h0000;
        lu_b      = 16'h0000;
        lu_op     = 4'h0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_s && (gnt_idx_s == IDW'(i))) begin
                req_ready[i] = 1'b1;
                lu_a         = req_a[16*i +: 16];
                lu_b         = req_b[16*i +: 16];
                lu_op        = req_op[4*i +: 4];
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    // Response slot: refill on a transfer (even while draining), else empty on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_data_r  <= 16'h0000;
            rsp_flags_r <= 4'b0000;
            ptr_r       <= '0;
        end else if (grant_s) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= gnt_idx_s;
            rsp_data_r  <= lu_out;
            rsp_flags_r <= {lu_eq, lu_gt, lu_za, lu_zb};
            ptr_r       <= ring_add(gnt_idx_s, ONE_W);
        end else if (rsp_valid_r && rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    // Consumed-response counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_count_r <= 16'h0000;
        end else if (rsp_valid_r && rsp_ready) begin
            rsp_count_r <= rsp_count_r + 16'h0001;
        end else begin
            rsp_count_r <= rsp_count_r;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_flags = rsp_flags_r;
    assign rsp_count = rsp_count_r;

endmodule

// File: tb/tb_lu_arbiter.sv
// Bench for lu_arbiter: a small logic-unit model feeds the DUT, a transaction-level
// model of the arbiter is checked every cycle, and directed steps pin literal values.
module tb_lu_arbiter;
    localparam int NREQ = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*16-1:0]   req_a, req_b;
    logic [NREQ*4-1:0]    req_op;
    logic [NREQ-1:0]      req_ready;
    logic [15:0]          lu_a, lu_b, lu_out;
    logic [3:0]           lu_op;
    logic                 lu_eq, lu_gt, lu_za, lu_zb;
    logic                 rsp_valid, rsp_ready;
    logic [1:0]           rsp_id;
    logic [15:0]          rsp_data, rsp_count;
    logic [3:0]           rsp_flags;

    int total = 0;
    int bad   = 0;

    // Transaction-level model of the arbiter
    int          m_ptr   = 0;
    bit          m_valid = 1'b0;
    int          m_id    = 0;
    logic [15:0] m_data  = 16'h0000;
    logic [3:0]  m_flags = 4'b0000;
    int          m_count = 0;

    int rr_exp [6] = '{0, 1, 2, 3, 0, 1};

    always #5 clk = ~clk;

    lu_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .req_ready(req_ready), .lu_a(lu_a), .lu_b(lu_b), .lu_op(lu_op),
        .lu_out(lu_out), .lu_eq(lu_eq), .lu_gt(lu_gt), .lu_za(lu_za), .lu_zb(lu_zb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .rsp_count(rsp_count)
    );

    // Logic unit: AND, OR, XOR, NOT A; any other opcode yields zero.
    function automatic logic [15:0] ref_data(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        case (op)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a ^ b;
            4'h3:    return ~a;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [3:0] ref_flags(input logic [15:0] a, input logic [15:0] b);
        return {a == b, a > b, a == 16'h0000, b == 16'h0000};
    endfunction

    always_comb begin
        lu_out = ref_data(lu_a, lu_b, lu_op);
        {lu_eq, lu_gt, lu_za, lu_zb} = ref_flags(lu_a, lu_b);
    end

    function automatic int exp_grant();
        if (m_valid && !rsp_ready) return -1;
        for (int k = 0; k < NREQ; k++)
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [15:0] sel_a(input int g);
        if (g < 0) return 16'h0000;
        return req_a[16*g +: 16];
    endfunction

    function automatic logic [15:0] sel_b(input int g);
        if (g < 0) return 16'h0000;
        return req_b[16*g +: 16];
    endfunction

    function automatic logic [3:0] sel_op(input int g);
        if (g < 0) return 4'h0;
        return req_op[4*g +: 4];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state update on each clock edge; async reset clears it immediately.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr <= 0; m_valid <= 1'b0; m_id <= 0;
            m_data <= 16'h0000; m_flags <= 4'b0000; m_count <= 0;
        end else begin
            if (m_valid && rsp_ready) m_count <= (m_count + 1) % 65536;
            if (exp_grant() >= 0) begin
                m_valid <= 1'b1;
                m_id    <= exp_grant();
                m_data  <= ref_data(sel_a(exp_grant()), sel_b(exp_grant()), sel_op(exp_grant()));
                m_flags <= ref_flags(sel_a(exp_grant()), sel_b(exp_grant()));
                m_ptr   <= (exp_grant() + 1) % NREQ;
            end else if (m_valid && rsp_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_ready",  32'(req_ready), 32'(onehot(exp_grant())));
        chk("m_lu_a",   32'(lu_a),      32'(sel_a(exp_grant())));
        chk("m_lu_b",   32'(lu_b),      32'(sel_b(exp_grant())));
        chk("m_lu_op",  32'(lu_op),     32'(sel_op(exp_grant())));
        chk("m_valid",  32'(rsp_valid), 32'(m_valid));
        chk("m_id",     32'(rsp_id),    32'(m_id));
        chk("m_data",   32'(rsp_data),  32'(m_data));
        chk("m_flags",  32'(rsp_flags), 32'(m_flags));
        chk("m_count",  32'(rsp_count), 32'(m_count));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_op[4*i +: 4]  = op;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset
        repeat (5) begin
            tick(); #1;
            chk("idle_valid", 32'(rsp_valid), 32'h0);
            chk("idle_ready", 32'(req_ready), 32'h0);
            chk("idle_lu",    32'({lu_a, lu_b} | 32'(lu_op)), 32'h0);
            chk("idle_count", 32'(rsp_count), 32'h0);
        end

        // Single op from requester 2 (0x00FF is below 0x0F0F unsigned, so gt stays 0)
        set_req(2, 16'h00FF, 16'h0F0F, 4'h0);
        req_valid = 4'b0100;
        #1;
        chk("single_ready", 32'(req_ready), 32'h4);
        chk("single_lu_a",  32'(lu_a), 32'h00FF);
        tick(); req_valid = '0; #1;
        chk("single_valid", 32'(rsp_valid), 32'h1);
        chk("single_id",    32'(rsp_id),    32'h2);
        chk("single_data",  32'(rsp_data),  32'h000F);
        chk("single_flags", 32'(rsp_flags), 32'h0);
        chk("single_cnt0",  32'(rsp_count), 32'h0);
        tick(); #1;
        chk("single_cnt1",  32'(rsp_count), 32'h1);
        chk("single_empty", 32'(rsp_valid), 32'h0);

        // Round robin with all requesters valid
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 16'(16'h1111 * (i + 1)), 16'(16'h0101 << i), 4'(i));
        req_valid = 4'b1111;
        for (int j = 0; j < 6; j++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(4'b0001 << rr_exp[j]));
            if (j > 0) chk("rr_id", 32'(rsp_id), 32'(rr_exp[j-1]));
            tick();
        end
        #1;
        chk("rr_last_id", 32'(rsp_id), 32'h1);
        req_valid = '0;
        tick();

        // Single requester back-to-back
        req_valid = 4'b0010;
        repeat (3) begin
            #1;
            chk("solo_ready", 32'(req_ready), 32'h2);
            tick();
        end
        req_valid = '0;
        #1;
        chk("solo_id", 32'(rsp_id), 32'h1);
        tick();

        // Backpressure with requesters 1 and 3
        do_reset();
        set_req(1, 16'hA5A5, 16'h5A5A, 4'h2);
        set_req(3, 16'h1234, 16'h1234, 4'h0);
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        #1;
        chk("bp_first", 32'(req_ready), 32'h2);
        tick(); req_valid = 4'b1000;
        repeat (3) begin
            #1;
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_id",    32'(rsp_id),    32'h1);
            chk("bp_data",  32'(rsp_data),  32'hFFFF);
            chk("bp_ready", 32'(req_ready), 32'h0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release", 32'(req_ready), 32'h8);
        tick(); req_valid = '0; #1;
        chk("bp_id3",    32'(rsp_id),    32'h3);
        chk("bp_data3",  32'(rsp_data),  32'h1234);
        chk("bp_flags3", 32'(rsp_flags), 32'h8);
        chk("bp_cnt1",   32'(rsp_count), 32'h1);
        tick(); #1;
        chk("bp_cnt2",   32'(rsp_count), 32'h2);

        // Undefined opcode with zero operands
        set_req(0, 16'h0000, 16'h0000, 4'hF);
        req_valid = 4'b0001;
        tick(); req_valid = '0; #1;
        chk("undef_data",  32'(rsp_data),  32'h0);
        chk("undef_flags", 32'(rsp_flags), 32'hB);
        tick();

        // Async reset with a held response
        rsp_ready = 1'b0;
        set_req(2, 16'h0F00, 16'h00F0, 4'h1);
        req_valid = 4'b0100;
        tick(); req_valid = '0; #1;
        chk("ar_pending", 32'(rsp_valid), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(rsp_valid), 32'h0);
        chk("ar_count", 32'(rsp_count), 32'h0);
        tick(); rst_n = 1'b1; rsp_ready = 1'b1;
        set_req(0, 16'h0003, 16'h0001, 4'h1);
        set_req(3, 16'h0007, 16'h0007, 4'h0);
        req_valid = 4'b1001;
        #1;
        chk("ar_grant0", 32'(req_ready), 32'h1);
        tick(); req_valid = '0; #1;
        chk("ar_id0",    32'(rsp_id),    32'h0);
        chk("ar_data0",  32'(rsp_data),  32'h0003);
        chk("ar_cnt0",   32'(rsp_count), 32'h0);
        tick(); #1;
        chk("ar_cnt1",   32'(rsp_count), 32'h1);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
